// File: rtl/pipe_ctrl_pkg.sv
// Shared hold-level encodings and helpers for the pipeline controller.
// Hold levels are ordered so that a larger code always means a deeper stall.
package pipe_ctrl_pkg;

    localparam int Hold_Flag_Bus = 3;

    typedef logic [Hold_Flag_Bus-1:0] hold_t;

    localparam hold_t Hold_None = 3'd0;
    localparam hold_t Hold_Pc   = 3'd1;
    localparam hold_t Hold_If   = 3'd2;
    localparam hold_t Hold_Id   = 3'd3;

    function automatic hold_t hold_max(input hold_t a, input hold_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Bus watchdog: counts consecutive bus stall cycles and flags the timeout cycle.
// The count saturates so a stall outlasting the 16-bit range cannot wrap around.
module pipe_ctrl_wdog #(
    parameter int BUS_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic bus_hold,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(BUS_TIMEOUT - 1);

    logic [15:0] count;
    logic [15:0] count_next;

    always_comb begin
        count_next = count;
        if (!bus_hold) begin
            count_next = 16'd0;
        end else if (count != 16'hFFFF) begin
            count_next = count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 16'd0;
        end else begin
            count <= count_next;
        end
    end

    assign timeout = bus_hold && (count == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates redirects and stall requests into a hold level,
// drives the PC redirect, flushes the front end and reports bus timeouts.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_jump_i,
    input  logic [31:0] int_addr_i,
    input  logic        int_hold_i,
    input  logic        ex_hold_i,
    input  logic        bus_hold_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_err_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        BUS_ERR = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_next;
    logic        bus_err_next;
    logic [31:0] stall_cnt_next;
    logic        redirect;
    logic        flush_active;
    logic        timeout;
    hold_t       id_level;
    hold_t       pc_level;

    pipe_ctrl_wdog #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rstn     (rstn),
        .bus_hold (bus_hold_i),
        .timeout  (timeout)
    );

    assign redirect     = int_jump_i | jump_req_i;
    assign flush_active = (flush_cnt != 4'd0);

    // A redirect always reloads, even mid-flush or while in BUS_ERR.
    always_comb begin
        flush_cnt_next = flush_cnt;
        if (redirect) begin
            flush_cnt_next = FLUSH_LOAD;
        end else if (flush_active) begin
            flush_cnt_next = flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (timeout) begin
                    state_next = BUS_ERR;
                end else if (redirect && (FLUSH_CYCLES > 1)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (timeout) begin
                    state_next = BUS_ERR;
                end else if (flush_cnt_next == 4'd0) begin
                    state_next = RUN;
                end
            end
            BUS_ERR: begin
                if (!bus_hold_i) begin
                    state_next = (flush_cnt_next != 4'd0) ? FLUSH : RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        jump_flag_o = redirect;
        jump_addr_o = 32'd0;
        if (int_jump_i) begin
            jump_addr_o = int_addr_i;
        end else if (jump_req_i) begin
            jump_addr_o = jump_addr_i;
        end

        id_level = Hold_None;
        if (redirect || flush_active || (state == FLUSH) || int_hold_i || ex_hold_i) begin
            id_level = Hold_Id;
        end
        // Bus stall is masked once the timeout has been reported.
        pc_level = Hold_None;
        if (bus_hold_i && (state != BUS_ERR)) begin
            pc_level = Hold_Pc;
        end
        hold_flag_o = hold_max(id_level, pc_level);
    end

    assign bus_err_next = timeout && (state != BUS_ERR);

    always_comb begin
        stall_cnt_next = stall_cnt_o;
        if ((hold_flag_o != Hold_None) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_next = stall_cnt_o + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_cnt   <= 4'd0;
            bus_err_o   <= 1'b0;
            stall_cnt_o <= 32'd0;
        end else begin
            flush_cnt   <= flush_cnt_next;
            bus_err_o   <= bus_err_next;
            stall_cnt_o <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: redirects, priority, back-to-back flush,
// stall mixing, bus timeout and asynchronous reset mid-flush.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_jump_i;
    logic [31:0] int_addr_i;
    logic        int_hold_i;
    logic        ex_hold_i;
    logic        bus_hold_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        bus_err_o;
    logic [31:0] stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] H_NONE = 3'd0;
    localparam logic [2:0] H_PC   = 3'd1;
    localparam logic [2:0] H_ID   = 3'd3;

    pipe_ctrl #(
        .FLUSH_CYCLES(2),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .jump_req_i  (jump_req_i),
        .jump_addr_i (jump_addr_i),
        .int_jump_i  (int_jump_i),
        .int_addr_i  (int_addr_i),
        .int_hold_i  (int_hold_i),
        .ex_hold_i   (ex_hold_i),
        .bus_hold_i  (bus_hold_i),
        .hold_flag_o (hold_flag_o),
        .jump_flag_o (jump_flag_o),
        .jump_addr_o (jump_addr_o),
        .bus_err_o   (bus_err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Move just past the next rising edge; inputs change here, checks follow 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        jump_req_i  = 1'b0;
        jump_addr_i = 32'd0;
        int_jump_i  = 1'b0;
        int_addr_i  = 32'd0;
        int_hold_i  = 1'b0;
        ex_hold_i   = 1'b0;
        bus_hold_i  = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_hold",  32'(hold_flag_o), 32'(H_NONE));
        chk("rst_jflag", 32'(jump_flag_o), 32'd0);
        chk("rst_jaddr", jump_addr_o, 32'd0);
        chk("rst_berr",  32'(bus_err_o), 32'd0);
        chk("rst_stall", stall_cnt_o, 32'd0);
        rstn = 1'b1;
        $display("reset released");

        // Single jump: Hold_Id for exactly two cycles
        tick(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100; settle();
        $display("jump req addr=%h", jump_addr_i);
        chk("jmp_flag", 32'(jump_flag_o), 32'd1);
        chk("jmp_addr", jump_addr_o, 32'h0000_0100);
        chk("jmp_hold0", 32'(hold_flag_o), 32'(H_ID));
        chk("jmp_stall0", stall_cnt_o, 32'd0);
        tick(); jump_req_i = 1'b0; jump_addr_i = 32'h0000_0055; settle();
        $display("jump flush cycle");
        chk("jmp_hold1", 32'(hold_flag_o), 32'(H_ID));
        chk("jmp_flag1", 32'(jump_flag_o), 32'd0);
        chk("jmp_addr1", jump_addr_o, 32'd0);
        chk("jmp_stall1", stall_cnt_o, 32'd1);
        tick(); settle();
        $display("jump done");
        chk("jmp_hold2", 32'(hold_flag_o), 32'(H_NONE));
        chk("jmp_stall2", stall_cnt_o, 32'd2);

        // Priority: trap redirect beats branch redirect
        tick(); clear_inputs();
        int_jump_i = 1'b1; int_addr_i = 32'h0000_0008;
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100; settle();
        $display("int_jump + jump_req together");
        chk("pri_addr", jump_addr_o, 32'h0000_0008);
        chk("pri_flag", 32'(jump_flag_o), 32'd1);
        chk("pri_hold", 32'(hold_flag_o), 32'(H_ID));

        // Back-to-back: second jump during flush reloads the counter
        tick(); clear_inputs(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0200; settle();
        $display("second jump during flush");
        chk("b2b_flag", 32'(jump_flag_o), 32'd1);
        chk("b2b_addr", jump_addr_o, 32'h0000_0200);
        chk("b2b_hold0", 32'(hold_flag_o), 32'(H_ID));
        chk("b2b_stall0", stall_cnt_o, 32'd3);
        tick(); clear_inputs(); settle();
        $display("b2b flush cycle");
        chk("b2b_hold1", 32'(hold_flag_o), 32'(H_ID));
        chk("b2b_flag1", 32'(jump_flag_o), 32'd0);
        tick(); settle();
        $display("b2b done");
        chk("b2b_hold2", 32'(hold_flag_o), 32'(H_NONE));
        chk("b2b_stall2", stall_cnt_o, 32'd5);

        // Stall mix: max of sources
        tick(); ex_hold_i = 1'b1; bus_hold_i = 1'b1; settle();
        $display("ex_hold + bus_hold");
        chk("mix_id", 32'(hold_flag_o), 32'(H_ID));
        tick(); ex_hold_i = 1'b0; settle();
        $display("bus_hold only");
        chk("mix_pc", 32'(hold_flag_o), 32'(H_PC));
        tick(); bus_hold_i = 1'b0; settle();
        $display("no stall");
        chk("mix_none", 32'(hold_flag_o), 32'(H_NONE));
        chk("mix_stall", stall_cnt_o, 32'd7);

        // Bus timeout with BUS_TIMEOUT=4
        for (int i = 0; i < 4; i++) begin
            tick(); bus_hold_i = 1'b1; settle();
            $display("bus hold cycle %0d", i);
            chk("to_hold_pc", 32'(hold_flag_o), 32'(H_PC));
            chk("to_berr_lo", 32'(bus_err_o), 32'd0);
        end
        tick(); settle();
        $display("bus timeout cycle");
        chk("to_berr_hi", 32'(bus_err_o), 32'd1);
        chk("to_hold_masked", 32'(hold_flag_o), 32'(H_NONE));
        chk("to_stall", stall_cnt_o, 32'd11);
        tick(); settle();
        $display("bus_err held off");
        chk("to_berr_pulse", 32'(bus_err_o), 32'd0);
        chk("to_hold_masked2", 32'(hold_flag_o), 32'(H_NONE));
        tick(); bus_hold_i = 1'b0; settle();
        $display("bus hold dropped");
        chk("to_release", 32'(hold_flag_o), 32'(H_NONE));
        tick(); bus_hold_i = 1'b1; settle();
        $display("bus hold after return to RUN");
        chk("to_run_pc", 32'(hold_flag_o), 32'(H_PC));
        chk("to_run_berr", 32'(bus_err_o), 32'd0);

        // Reset asserted mid-flush
        tick(); bus_hold_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0300; settle();
        $display("jump before reset");
        chk("rf_flag", 32'(jump_flag_o), 32'd1);
        tick(); clear_inputs(); settle();
        $display("mid flush");
        chk("rf_hold_pre", 32'(hold_flag_o), 32'(H_ID));
        chk("rf_stall_pre", stall_cnt_o, 32'd13);
        rstn = 1'b0; #1;
        $display("reset asserted mid flush");
        chk("rf_hold", 32'(hold_flag_o), 32'(H_NONE));
        chk("rf_jflag", 32'(jump_flag_o), 32'd0);
        chk("rf_stall", stall_cnt_o, 32'd0);
        chk("rf_berr", 32'(bus_err_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(); settle();
        $display("after reset release");
        chk("rf_run_hold", 32'(hold_flag_o), 32'(H_NONE));
        chk("rf_run_stall", stall_cnt_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
